// File: rtl/ray_word_unpacker_if.sv
// rtl/ray_word_unpacker_if.sv - ray FIFO read side and record output bundle
interface ray_word_unpacker_if #(
  parameter int WORDS_PER_REC = 6
);
  logic [35:0]                 fifo_rd_data;
  logic                        fifo_empty;
  logic                        fifo_rd_en;
  logic [32*WORDS_PER_REC-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  // The unpacker pops the FIFO and sources the record stream.
  modport master (
    input  fifo_rd_data, fifo_empty, out_ready,
    output fifo_rd_en, out_data, out_valid
  );

  // FIFO read port plus the downstream intersection stage.
  modport slave (
    output fifo_rd_data, fifo_empty, out_ready,
    input  fifo_rd_en, out_data, out_valid
  );
endinterface

// File: rtl/ray_word_unpacker.sv
// rtl/ray_word_unpacker.sv - pops tagged 36-bit ray words and assembles wide records; FRAME_CHECK_EN enables SOP/EOP framing checks
module ray_word_unpacker #(
  parameter int WORDS_PER_REC = 6,
  parameter int RD_LAT        = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  ray_word_unpacker_if.master bus,
  output logic                busy,
  output logic                frame_err,
  output logic [15:0]         err_count
);

  localparam logic [4:0] WPR  = 5'(WORDS_PER_REC);
  localparam logic [4:0] LAST = 5'(WORDS_PER_REC - 1);

  logic [4:0]                  inflight;
  logic [4:0]                  asm_count;
  logic [RD_LAT-1:0]           vld_line;
  logic                        run;
  logic [31:0]                 asm_buf [WORDS_PER_REC];
  logic [32*WORDS_PER_REC-1:0] rec_next;

  logic       issue;
  logic       arrive;
  logic       slot_free;
  logic [5:0] credit_used;
  logic [31:0] payload;
  logic [3:0] tag_unused;
  logic [4:0] wr_idx;
  logic       drop;
  logic       is_last;
  logic       err_now;

  // Words already issued or already held both consume credit, so a held
  // record can never be overrun by returning reads.
  assign credit_used   = {1'b0, inflight} + {1'b0, asm_count};
  assign issue         = run && !bus.fifo_empty && (credit_used < 6'(WORDS_PER_REC));
  assign bus.fifo_rd_en = issue;
  assign arrive        = vld_line[RD_LAT-1];
  assign slot_free     = !bus.out_valid || bus.out_ready;
  assign payload       = bus.fifo_rd_data[31:0];
  assign tag_unused    = bus.fifo_rd_data[35:32];
  assign busy          = (inflight != 5'd0) || (asm_count != 5'd0) || bus.out_valid;

`ifdef FRAME_CHECK_EN
  logic sop;
  logic eop;
  assign sop = bus.fifo_rd_data[35];
  assign eop = bus.fifo_rd_data[34];
`endif

  // Classify the arriving word: where it lands, whether it closes a record, framing faults
  always_comb begin
    wr_idx  = asm_count;
    drop    = 1'b0;
    is_last = 1'b0;
    err_now = 1'b0;
`ifdef FRAME_CHECK_EN
    if (arrive) begin
      if (sop && asm_count != 5'd0) begin
        wr_idx = 5'd0;
      end else if (!sop && asm_count == 5'd0) begin
        drop = 1'b1;
      end
      is_last = !drop && (wr_idx == LAST);
      err_now = drop || (wr_idx != asm_count) || (eop != is_last);
    end
`else
    is_last = arrive && (asm_count == LAST);
`endif
  end

  // Record image for hand-off; the closing word bypasses the buffer so the
  // record leaves on the same edge it completes.
  always_comb begin
    rec_next = '0;
    for (int k = 0; k < WORDS_PER_REC; k++) begin
      rec_next[32*k +: 32] = (is_last && (5'(k) == LAST)) ? payload : asm_buf[k];
    end
  end

  // Credit tracking, arrival delay line, assembly and output hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run           <= 1'b0;
      inflight      <= 5'd0;
      asm_count     <= 5'd0;
      vld_line      <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      frame_err     <= 1'b0;
      err_count     <= 16'd0;
      for (int k = 0; k < WORDS_PER_REC; k++) begin
        asm_buf[k] <= 32'd0;
      end
    end else begin
      run      <= 1'b1;
      vld_line <= RD_LAT'({vld_line, issue});
      inflight <= inflight + 5'(issue) - 5'(arrive);

      if (bus.out_valid && bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end

      if (asm_count == WPR) begin
        if (slot_free) begin
          bus.out_data  <= rec_next;
          bus.out_valid <= 1'b1;
          asm_count     <= 5'd0;
        end
      end else if (arrive && !drop) begin
        if (is_last && slot_free) begin
          bus.out_data  <= rec_next;
          bus.out_valid <= 1'b1;
          asm_count     <= 5'd0;
        end else begin
          for (int k = 0; k < WORDS_PER_REC; k++) begin
            if (wr_idx == 5'(k)) begin
              asm_buf[k] <= payload;
            end
          end
          asm_count <= wr_idx + 5'd1;
        end
      end

      frame_err <= err_now;
      if (err_now && err_count != 16'hFFFF) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

endmodule
